// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: a one-entry pipeline register between fetch and execute.
// Each accepted instruction is decoded into register addresses, a sign-extended
// immediate, an ALU operation and control strobes, all presented from flops.
module rv32i_decode_stage #(
    parameter logic [31:0] NOOP_INSTRUCTION = 32'h00000013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_instruction,
    input  logic [31:0] i_fetch_pc,
    output logic        o_decode_ready,
    input  logic        i_branch_miss,
    input  logic        i_exec_ready,
    output logic        o_decode_valid,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_imm,
    output logic [3:0]  o_alu_op,
    output logic [2:0]  o_funct3,
    output logic        o_alu_src_imm,
    output logic        o_reg_wr_en,
    output logic        o_mem_rd_en,
    output logic        o_mem_wr_en,
    output logic        o_branch,
    output logic        o_jump,
    output logic        o_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic        alu_src_imm;
        logic        reg_wr_en;
        logic        mem_rd_en;
        logic        mem_wr_en;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    localparam dec_t DEC_ZERO = {$bits(dec_t){1'b0}};

    // Map funct3 (plus the instr[30] alternate bit) onto an ALU operation.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Fully decode one instruction word into the entry held by the stage.
    function automatic dec_t decode_instr(input logic [31:0] instr);
        dec_t        d;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] imm_j;
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'h000};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        d        = DEC_ZERO;
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.rd     = instr[11:7];
        d.funct3 = instr[14:12];
        case (instr[6:0])
            OPC_LUI:    begin d.imm = imm_u; d.alu_op = ALU_PASSB; d.alu_src_imm = 1'b1; d.reg_wr_en = 1'b1; end
            OPC_AUIPC:  begin d.imm = imm_u; d.alu_op = ALU_ADD; d.alu_src_imm = 1'b1; d.reg_wr_en = 1'b1; end
            OPC_JAL:    begin d.imm = imm_j; d.alu_op = ALU_ADD; d.alu_src_imm = 1'b1; d.reg_wr_en = 1'b1; d.jump = 1'b1; end
            OPC_JALR:   begin d.imm = imm_i; d.alu_op = ALU_ADD; d.alu_src_imm = 1'b1; d.reg_wr_en = 1'b1; d.jump = 1'b1; end
            OPC_BRANCH: begin d.imm = imm_b; d.alu_op = ALU_SUB; d.branch = 1'b1; end
            OPC_LOAD:   begin d.imm = imm_i; d.alu_op = ALU_ADD; d.alu_src_imm = 1'b1; d.reg_wr_en = 1'b1; d.mem_rd_en = 1'b1; end
            OPC_STORE:  begin d.imm = imm_s; d.alu_op = ALU_ADD; d.alu_src_imm = 1'b1; d.mem_wr_en = 1'b1; end
            // Only the shift-right immediate form uses instr[30]; for ADDI it is an immediate bit.
            OPC_OP_IMM: begin
                d.imm         = imm_i;
                d.alu_op      = alu_from_funct3(instr[14:12], (instr[14:12] == 3'b101) & instr[30]);
                d.alu_src_imm = 1'b1;
                d.reg_wr_en   = 1'b1;
            end
            OPC_OP:     begin d.alu_op = alu_from_funct3(instr[14:12], instr[30]); d.reg_wr_en = 1'b1; end
            default:    begin d.illegal = 1'b1; end
        endcase
        // Writes to x0 are architecturally discarded, so never request them.
        d.reg_wr_en = d.reg_wr_en & (d.rd != 5'd0);
        // The configured bubble encoding must always look like a harmless legal entry.
        d.reg_wr_en = d.reg_wr_en & (instr != NOOP_INSTRUCTION);
        d.illegal   = d.illegal & (instr != NOOP_INSTRUCTION);
        return d;
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    dec_t        dec_q;
    dec_t        dec_d;
    dec_t        fetch_dec_s;
    logic        decode_ready_s;
    logic        accept_s;

    assign fetch_dec_s = decode_instr(i_fetch_instruction);

    // Handshake and next-state selection; a flush overrides accept and consume.
    always_comb begin
        decode_ready_s = ~i_rst & ~i_branch_miss & ((state_q == EMPTY) | i_exec_ready);
        accept_s       = i_fetch_valid & decode_ready_s;
        state_d        = state_q;
        pc_d           = pc_q;
        dec_d          = dec_q;
        if (i_branch_miss) begin
            state_d = EMPTY;
        end else if (accept_s) begin
            state_d = FULL;
            pc_d    = i_fetch_pc;
            dec_d   = fetch_dec_s;
        end else if ((state_q == FULL) && i_exec_ready) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Entry register; reset clears it immediately without waiting for a clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            pc_q    <= 32'h0000_0000;
            dec_q   <= DEC_ZERO;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dec_q   <= dec_d;
        end
    end

    assign o_decode_ready = decode_ready_s;
    assign o_decode_valid = (state_q == FULL);
    assign o_pc           = pc_q;
    assign o_rs1_addr     = dec_q.rs1;
    assign o_rs2_addr     = dec_q.rs2;
    assign o_rd_addr      = dec_q.rd;
    assign o_imm          = dec_q.imm;
    assign o_alu_op       = dec_q.alu_op;
    assign o_funct3       = dec_q.funct3;
    assign o_alu_src_imm  = dec_q.alu_src_imm;
    assign o_reg_wr_en    = dec_q.reg_wr_en;
    assign o_mem_rd_en    = dec_q.mem_rd_en;
    assign o_mem_wr_en    = dec_q.mem_wr_en;
    assign o_branch       = dec_q.branch;
    assign o_jump         = dec_q.jump;
    assign o_illegal      = dec_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: hand-decoded instruction table, a scoreboard
// queue of expected entries, and a small valid/ready model of the stage.
module tb_rv32i_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_fetch_valid;
    logic [31:0] i_fetch_instruction;
    logic [31:0] i_fetch_pc;
    logic        o_decode_ready;
    logic        i_branch_miss;
    logic        i_exec_ready;
    logic        o_decode_valid;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_imm;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_funct3;
    logic        o_alu_src_imm;
    logic        o_reg_wr_en;
    logic        o_mem_rd_en;
    logic        o_mem_wr_en;
    logic        o_branch;
    logic        o_jump;
    logic        o_illegal;

    rv32i_decode_stage #(.NOOP_INSTRUCTION(32'h00000013)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_fetch_valid(i_fetch_valid), .i_fetch_instruction(i_fetch_instruction),
        .i_fetch_pc(i_fetch_pc), .o_decode_ready(o_decode_ready),
        .i_branch_miss(i_branch_miss), .i_exec_ready(i_exec_ready),
        .o_decode_valid(o_decode_valid), .o_pc(o_pc),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
        .o_imm(o_imm), .o_alu_op(o_alu_op), .o_funct3(o_funct3),
        .o_alu_src_imm(o_alu_src_imm), .o_reg_wr_en(o_reg_wr_en),
        .o_mem_rd_en(o_mem_rd_en), .o_mem_wr_en(o_mem_wr_en),
        .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // lvl: 0 = check every field, 1 = alu_src_imm unspecified, 2 = illegal (control only)
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        src;
        logic        wr;
        logic        mrd;
        logic        mwr;
        logic        br;
        logic        j;
        logic        ill;
        int          lvl;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t sb_q[$];
    vec_t cur;
    logic mvalid;
    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [3:0] alu, input logic [2:0] f3,
                                input logic src, input logic wr, input logic mrd, input logic mwr,
                                input logic br, input logic j, input logic ill, input int lvl);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.alu = alu; v.f3 = f3; v.src = src; v.wr = wr; v.mrd = mrd; v.mwr = mwr;
        v.br = br; v.j = j; v.ill = ill; v.lvl = lvl;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic chk_entry(input string ctx, input vec_t e);
        chk({ctx, "_pc"},  o_pc, e.pc);
        chk({ctx, "_wr"},  {31'd0, o_reg_wr_en}, {31'd0, e.wr});
        chk({ctx, "_mrd"}, {31'd0, o_mem_rd_en}, {31'd0, e.mrd});
        chk({ctx, "_mwr"}, {31'd0, o_mem_wr_en}, {31'd0, e.mwr});
        chk({ctx, "_br"},  {31'd0, o_branch},    {31'd0, e.br});
        chk({ctx, "_j"},   {31'd0, o_jump},      {31'd0, e.j});
        chk({ctx, "_ill"}, {31'd0, o_illegal},   {31'd0, e.ill});
        if (e.lvl < 2) begin
            chk({ctx, "_rd"},  {27'd0, o_rd_addr},  {27'd0, e.rd});
            chk({ctx, "_rs1"}, {27'd0, o_rs1_addr}, {27'd0, e.rs1});
            chk({ctx, "_rs2"}, {27'd0, o_rs2_addr}, {27'd0, e.rs2});
            chk({ctx, "_imm"}, o_imm, e.imm);
            chk({ctx, "_alu"}, {28'd0, o_alu_op}, {28'd0, e.alu});
            chk({ctx, "_f3"},  {29'd0, o_funct3}, {29'd0, e.f3});
        end
        if (e.lvl == 0) begin
            chk({ctx, "_src"}, {31'd0, o_alu_src_imm}, {31'd0, e.src});
        end
    endtask

    // One clock of stimulus: drive at the falling edge, check ready, then check outputs
    // at the next falling edge against the model and the scoreboard.
    task automatic cycle(input logic fv, input vec_t v, input logic bm, input logic er);
        logic exp_rdy;
        logic acc;
        logic new_entry;
        i_fetch_valid       = fv;
        i_fetch_instruction = v.instr;
        i_fetch_pc          = v.pc;
        i_branch_miss       = bm;
        i_exec_ready        = er;
        #1;
        exp_rdy = ~bm & (~mvalid | er);
        chk("ready", {31'd0, o_decode_ready}, {31'd0, exp_rdy});
        acc = fv & exp_rdy;
        if (acc) sb_q.push_back(v);
        @(posedge i_clk);
        new_entry = 1'b0;
        if (bm) begin
            mvalid = 1'b0;
        end else if (acc) begin
            mvalid    = 1'b1;
            new_entry = 1'b1;
        end else if (mvalid && er) begin
            mvalid = 1'b0;
        end
        @(negedge i_clk);
        chk("valid", {31'd0, o_decode_valid}, {31'd0, mvalid});
        if (new_entry) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                cur = sb_q.pop_front();
                chk_entry("new", cur);
            end
        end else if (mvalid) begin
            chk_entry("hold", cur);
        end
    endtask

    task automatic chk_all_zero(input string ctx);
        chk({ctx, "_valid"}, {31'd0, o_decode_valid}, 32'd0);
        chk({ctx, "_ready"}, {31'd0, o_decode_ready}, 32'd0);
        chk({ctx, "_pc"},    o_pc, 32'd0);
        chk({ctx, "_imm"},   o_imm, 32'd0);
        chk({ctx, "_regs"},  {17'd0, o_rs1_addr, o_rs2_addr, o_rd_addr}, 32'd0);
        chk({ctx, "_alu"},   {25'd0, o_alu_op, o_funct3}, 32'd0);
        chk({ctx, "_ctl"},   {25'd0, o_alu_src_imm, o_reg_wr_en, o_mem_rd_en, o_mem_wr_en,
                              o_branch, o_jump, o_illegal}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v_addi, v_sw, v_lui, v_sub, v_sra, v_nop, v_ill;
        v_addi = mk(32'hFFF10093, 32'h100, 5'd1, 5'd2, 5'd31, 32'hFFFFFFFF, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        v_sw   = mk(32'h00532423, 32'h104, 5'd8, 5'd6, 5'd5, 32'h00000008, 4'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        v_lui  = mk(32'h123452B7, 32'h108, 5'd5, 5'd8, 5'd3, 32'h12345000, 4'd10, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        v_sub  = mk(32'h402081B3, 32'h10C, 5'd3, 5'd1, 5'd2, 32'h00000000, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        v_sra  = mk(32'h4062D233, 32'h110, 5'd4, 5'd5, 5'd6, 32'h00000000, 4'd7, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        v_nop  = mk(32'h00000013, 32'h128, 5'd0, 5'd0, 5'd0, 32'h00000000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        v_ill  = mk(32'hFFFFFFFF, 32'h130, 5'd31, 5'd31, 5'd31, 32'h0, 4'd0, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        tbl.push_back(v_addi);
        tbl.push_back(v_sw);
        tbl.push_back(v_lui);
        tbl.push_back(v_sub);
        tbl.push_back(v_sra);
        tbl.push_back(mk(32'h40345393, 32'h114, 5'd7, 5'd8, 5'd3, 32'h00000403, 4'd7, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        tbl.push_back(mk(32'h40000493, 32'h118, 5'd9, 5'd0, 5'd0, 32'h00000400, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        tbl.push_back(mk(32'hFE208CE3, 32'h11C, 5'd25, 5'd1, 5'd2, 32'hFFFFFFF8, 4'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        tbl.push_back(mk(32'hFFC5A503, 32'h120, 5'd10, 5'd11, 5'd28, 32'hFFFFFFFC, 4'd0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        tbl.push_back(mk(32'h80000017, 32'h124, 5'd0, 5'd0, 5'd0, 32'h80000000, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        tbl.push_back(v_nop);
        tbl.push_back(mk(32'h001000EF, 32'h12C, 5'd1, 5'd0, 5'd1, 32'h00000800, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1));

        // Reset state, held across clock edges.
        i_rst = 1'b1; i_fetch_valid = 1'b0; i_fetch_instruction = 32'h0; i_fetch_pc = 32'h0;
        i_branch_miss = 1'b0; i_exec_ready = 1'b0; mvalid = 1'b0; cur = v_nop;
        #2;
        chk_all_zero("rst");
        @(negedge i_clk);
        @(negedge i_clk);
        chk_all_zero("rst_held");
        i_rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, o_decode_ready}, 32'd1);

        // Back-to-back stream of every table entry, then drain.
        foreach (tbl[k]) cycle(1'b1, tbl[k], 1'b0, 1'b1);
        cycle(1'b0, v_nop, 1'b0, 1'b1);

        // Stall three cycles with fetch data pending, then release.
        cycle(1'b1, v_sw, 1'b0, 1'b1);
        for (int s = 0; s < 3; s++) cycle(1'b1, v_lui, 1'b0, 1'b0);
        cycle(1'b1, v_lui, 1'b0, 1'b1);
        cycle(1'b0, v_nop, 1'b0, 1'b0);

        // Flush while full, with and without execute consuming.
        cycle(1'b1, v_sub, 1'b1, 1'b0);
        cycle(1'b1, v_sub, 1'b0, 1'b1);
        cycle(1'b1, v_sra, 1'b1, 1'b1);
        cycle(1'b0, v_nop, 1'b0, 1'b1);

        // Illegal entry, then an asynchronous reset in the middle of the cycle.
        cycle(1'b1, v_ill, 1'b0, 1'b1);
        i_exec_ready = 1'b0;
        i_fetch_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        mvalid = 1'b0;
        sb_q.delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("ready_after_mid_rst", {31'd0, o_decode_ready}, 32'd1);
        cycle(1'b1, v_addi, 1'b0, 1'b1);
        cycle(1'b0, v_nop, 1'b0, 1'b1);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
